// File: rtl/pstats_trig_counter.sv
// Per-port statistics trigger counter: parallel edge detect, pending latch, round-robin commit.
// Optional build macro PSTATS_CLR_ON_READ_EN makes in-range reads clear the counter read.
module pstats_trig_counter #(
   parameter int unsigned g_trig_width = 10,
   parameter int unsigned g_cnt_width  = 32,
   parameter int unsigned g_addr_width = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [g_trig_width-1:0] trig_i,
   input  logic                    clr_all_i,
   input  logic                    rd_req_i,
   input  logic [g_addr_width-1:0] rd_addr_i,
   output logic                    rd_valid_o,
   output logic [g_cnt_width-1:0]  rd_data_o,
   output logic [15:0]             lost_cnt_o,
   output logic                    busy_o
);

   localparam int unsigned c_idx_w = (g_trig_width > 1) ? $clog2(g_trig_width) : 1;

   logic [g_trig_width-1:0] r_trig_d;
   logic [g_trig_width-1:0] r_pending;
   logic [g_cnt_width-1:0]  r_cnt [g_trig_width];
   logic [c_idx_w-1:0]      r_idx;
   logic [15:0]             r_lost;
   logic                    r_rd_valid;
   logic [g_cnt_width-1:0]  r_rd_data;
   logic                    r_busy;

   logic [g_trig_width-1:0] w_ev;
   logic [g_trig_width-1:0] w_svc;
   logic [g_trig_width-1:0] w_collide;
   logic [g_trig_width-1:0] w_pend_nxt;
   logic [g_trig_width-1:0] w_rd_clr;
   logic [5:0]              w_ncol;
   logic [16:0]             w_lost_sum;
   logic [15:0]             w_lost_nxt;
   logic [g_cnt_width-1:0]  w_rd_val;
   logic [c_idx_w-1:0]      w_idx_nxt;

   always_comb begin
      w_ev       = trig_i & ~r_trig_d;
      w_svc      = '0;
      w_rd_clr   = '0;
      w_rd_val   = '0;
      w_ncol     = '0;
      for (int unsigned n = 0; n < g_trig_width; n++) begin
         w_svc[n] = (r_idx == c_idx_w'(n)) && r_pending[n];
         if (32'(rd_addr_i) == n) begin
            w_rd_val = r_cnt[n];
`ifdef PSTATS_CLR_ON_READ_EN
            w_rd_clr[n] = rd_req_i;
`endif
         end
      end
      // A line serviced on the same edge as its new event re-arms instead of colliding
      w_collide  = w_ev & r_pending & ~w_svc;
      w_pend_nxt = (r_pending & ~w_svc) | w_ev;
      for (int unsigned n = 0; n < g_trig_width; n++) begin
         w_ncol = w_ncol + 6'(w_collide[n]);
      end
      w_lost_sum = {1'b0, r_lost} + 17'(w_ncol);
      w_lost_nxt = w_lost_sum[16] ? 16'hFFFF : w_lost_sum[15:0];
      w_idx_nxt  = (r_idx == c_idx_w'(g_trig_width - 1)) ? '0 : r_idx + c_idx_w'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_trig_d   <= '1;
         r_pending  <= '0;
         r_idx      <= '0;
         r_lost     <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_busy     <= 1'b0;
         for (int unsigned n = 0; n < g_trig_width; n++) begin
            r_cnt[n] <= '0;
         end
      end else begin
         r_trig_d   <= trig_i;
         r_idx      <= w_idx_nxt;
         r_rd_valid <= rd_req_i;
         if (rd_req_i) begin
            r_rd_data <= w_rd_val;
         end
         if (clr_all_i) begin
            r_pending <= '0;
            r_busy    <= 1'b0;
            for (int unsigned n = 0; n < g_trig_width; n++) begin
               r_cnt[n] <= '0;
            end
         end else begin
            r_pending <= w_pend_nxt;
            r_busy    <= |w_pend_nxt;
            r_lost    <= w_lost_nxt;
            // Clear-on-read folds a simultaneous increment into the fresh count
            for (int unsigned n = 0; n < g_trig_width; n++) begin
               if (w_rd_clr[n]) begin
                  r_cnt[n] <= w_svc[n] ? g_cnt_width'(1) : '0;
               end else if (w_svc[n]) begin
                  r_cnt[n] <= r_cnt[n] + g_cnt_width'(1);
               end
            end
         end
      end
   end

   assign rd_valid_o = r_rd_valid;
   assign rd_data_o  = r_rd_data;
   assign lost_cnt_o = r_lost;
   assign busy_o     = r_busy;

endmodule

// File: tb/tb_pstats_trig_counter.sv
// Directed bench for pstats_trig_counter with a read scoreboard; second instance checks wrap.
// Expectations follow PSTATS_CLR_ON_READ_EN when it is defined.
module tb_pstats_trig_counter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr, rd_req;
   logic [9:0]  trig;
   logic [3:0]  addr;
   logic        rd_valid, busy;
   logic [31:0] rd_data;
   logic [15:0] lost;

   logic        rst2, rd_req2;
   logic [1:0]  trig2;
   logic [0:0]  addr2;
   logic        rd_valid2, busy2;
   logic [3:0]  rd_data2;
   logic [15:0] lost2;

   pstats_trig_counter #(.g_trig_width(10), .g_cnt_width(32), .g_addr_width(4)) u_dut (
      .clk_i(clk), .rst_i(rst), .trig_i(trig), .clr_all_i(clr), .rd_req_i(rd_req),
      .rd_addr_i(addr), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
      .lost_cnt_o(lost), .busy_o(busy));

   pstats_trig_counter #(.g_trig_width(2), .g_cnt_width(4), .g_addr_width(1)) u_w4 (
      .clk_i(clk), .rst_i(rst2), .trig_i(trig2), .clr_all_i(1'b0), .rd_req_i(rd_req2),
      .rd_addr_i(addr2), .rd_valid_o(rd_valid2), .rd_data_o(rd_data2),
      .lost_cnt_o(lost2), .busy_o(busy2));

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [31:0] exp_cnt [10];
   logic [31:0] sb [$];
   logic [3:0]  sb2 [$];
   int          tb_idx;
   logic [31:0] v, e;
   logic [15:0] lost_base;
   int          w;

   // Index the scanner will service on the next edge
   always @(posedge clk) begin
      if (rst) tb_idx <= 0;
      else     tb_idx <= (tb_idx == 9) ? 0 : tb_idx + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge; checks a one-cycle valid pulse and the scoreboard value
   task automatic do_read(input logic [3:0] a, input logic [31:0] ev, input string tag);
      logic [31:0] popped;
      rd_req = 1'b1;
      addr   = a;
      sb.push_back(ev);
      @(negedge clk);
      rd_req = 1'b0;
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      popped = sb.pop_front();
      chk(tag, rd_data, popped);
`ifdef PSTATS_CLR_ON_READ_EN
      if (a < 4'd10) exp_cnt[a] = '0;
`endif
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(rd_valid), 32'd0);
   endtask

   task automatic read_raw(input logic [3:0] a, output logic [31:0] val);
      rd_req = 1'b1;
      addr   = a;
      @(negedge clk);
      rd_req = 1'b0;
      chk("raw_valid", 32'(rd_valid), 32'd1);
      val = rd_data;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; clr = 1'b0; rd_req = 1'b0; addr = '0; trig = '0; trig[3] = 1'b1;
      rst2 = 1'b1; rd_req2 = 1'b0; addr2 = '0; trig2 = '0;
      for (int n = 0; n < 10; n++) exp_cnt[n] = '0;
      cyc(3);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_data", rd_data, 32'd0);
      chk("rst_lost", 32'(lost), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      // Line held high through reset release is not an event
      rst = 1'b0;
      cyc(20);
      do_read(4'd3, exp_cnt[3], "held_line");
      chk("held_busy", 32'(busy), 32'd0);
      trig[3] = 1'b0;
      @(negedge clk);
      trig[3] = 1'b1;
      @(negedge clk);
      trig[3] = 1'b0;
      exp_cnt[3] = exp_cnt[3] + 1;
      cyc(10);
      do_read(4'd3, exp_cnt[3], "first_edge");

      // All lines pulsed together, 100 times
      for (int r = 0; r < 100; r++) begin
         trig = '1;
         @(negedge clk);
         trig = '0;
         cyc(19);
      end
      for (int n = 0; n < 10; n++) exp_cnt[n] = exp_cnt[n] + 100;
      for (int n = 0; n < 10; n++) do_read(4'(n), exp_cnt[n], "burst");
      chk("burst_lost", 32'(lost), 32'd0);

      // Line 5 events faster than the scan period
      for (int k = 0; k < 50; k++) begin
         trig[5] = 1'b1;
         @(negedge clk);
         trig[5] = 1'b0;
         @(negedge clk);
      end
      cyc(20);
      read_raw(4'd5, v);
      chk("coll_sum", v + 32'(lost), exp_cnt[5] + 32'd50);
      chk("coll_lost_nz", 32'(lost != 16'd0), 32'd1);
      chk("coll_busy", 32'(busy), 32'd0);
      exp_cnt[5] = v;
`ifdef PSTATS_CLR_ON_READ_EN
      exp_cnt[5] = '0;
`endif
      lost_base = lost;

      // 4-bit counter wrap on the narrow instance
      rst2 = 1'b0;
      cyc(2);
      for (int k = 0; k < 16; k++) begin
         trig2[0] = 1'b1;
         @(negedge clk);
         trig2[0] = 1'b0;
         cyc(3);
      end
      cyc(4);
      rd_req2 = 1'b1;
      addr2   = 1'b0;
      sb2.push_back(4'h0);
      @(negedge clk);
      rd_req2 = 1'b0;
      chk("wrap_valid", 32'(rd_valid2), 32'd1);
      chk("wrap_data", 32'(rd_data2), 32'(sb2.pop_front()));
      @(negedge clk);
      chk("wrap_pulse", 32'(rd_valid2), 32'd0);
      chk("wrap_lost", 32'(lost2), 32'd0);

      // Clear, then read line 7 on the edge the scanner increments it
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      for (int n = 0; n < 10; n++) exp_cnt[n] = '0;
      chk("clr_lost", 32'(lost), 32'(lost_base));
      for (int k = 0; k < 4; k++) begin
         trig[7] = 1'b1;
         @(negedge clk);
         trig[7] = 1'b0;
         cyc(19);
      end
      w = 0;
      while (tb_idx != 5 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("align", 32'(w < 20), 32'd1);
      trig[7] = 1'b1;
      @(negedge clk);
      trig[7] = 1'b0;
      @(negedge clk);
      do_read(4'd7, 32'd4, "rd_on_inc");
`ifdef PSTATS_CLR_ON_READ_EN
      exp_cnt[7] = 32'd1;
`else
      exp_cnt[7] = 32'd5;
`endif
      do_read(4'd7, exp_cnt[7], "rd_after_inc");

      // Clear with all lines pending
      cyc(12);
      trig = '1;
      @(negedge clk);
      trig = '0;
      chk("pend_busy", 32'(busy), 32'd1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_lost2", 32'(lost), 32'(lost_base));
      for (int n = 0; n < 10; n++) exp_cnt[n] = '0;
      cyc(12);
      for (int n = 0; n < 10; n++) do_read(4'(n), exp_cnt[n], "clr_rd");
      e = '0;
      do_read(4'd12, e, "oor");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pstats_trig_counter.md
Name: pstats_trig_counter

Overview:
- Consumer end of the per-port statistics trigger interface: one counter per trigger line, incremented once per rising edge on that line.
- Sits between the per-port event sources (MAC/RTU event pulses) and the statistics register bank.
- Edge-detects all lines in parallel, latches events into pending bits, and commits them with a round-robin scanner (one counter per cycle).
- Provides a registered random-access read port for the CPU/wishbone side.

Parameters:
- g_trig_width, 10: number of trigger lines/counters; legal range 2..32.
- g_cnt_width, 32: width of each event counter.
- g_addr_width, 4: read address width; must satisfy 2^g_addr_width >= g_trig_width.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- trig_i  in  g_trig_width  event lines; level inputs, each event is a 0->1 transition held high >=1 clock.
- clr_all_i  in  1  synchronous clear of all counters and pending bits.
- rd_req_i  in  1  read strobe, one request per cycle, always accepted.
- rd_addr_i  in  g_addr_width  counter index to read.
- rd_valid_o  out  1  one-cycle pulse, data valid.
- rd_data_o  out  g_cnt_width  counter value.
- lost_cnt_o  out  16  total events dropped due to pending collision, saturating.
- busy_o  out  1  high while any pending bit is set.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - counters, pending, lost_cnt_o, rd_valid_o, rd_data_o, busy_o all go to 0; scanner index goes to 0.
  - Edge-detect register trig_d goes to all-ones, so a line already high when reset is released is not counted.
  - Reset mid-operation discards all pending events without counting them as lost.
- Edge detect: each edge, trig_d <= trig_i. ev[n] = trig_i[n] & ~trig_d[n] is evaluated on the same edge.
- Pending/scanner:
  - ev[n] sets pending[n].
  - Scanner index idx advances 0,1,...,g_trig_width-1,0 every cycle unconditionally.
  - On an edge where pending[idx]=1: cnt[idx] <= cnt[idx]+1 and pending[idx] is cleared.
  - If ev[idx] is also 1 on that edge, pending[idx] stays set and lost_cnt_o is unchanged.
- Latency: from the edge that detects ev[n] to the counter update is 1..g_trig_width cycles.
- Collision: ev[n]=1 while pending[n]=1 and not being serviced on that edge -> event dropped, lost_cnt_o += 1, saturating at 0xFFFF.
- Multiple collisions on the same edge add their count (popcount), saturating.
- Counter arithmetic: unsigned modulo 2^g_cnt_width; 0xFFFFFFFF + 1 -> 0, with no flag.
- clr_all_i:
  - Clears all counters and pending bits on that edge.
  - Has priority over scanner increments and new events on the same edge; those events are discarded and not counted as lost.
  - Does not clear lost_cnt_o; only rst_i clears it.
- Read:
  - rd_req_i at edge k -> rd_valid_o=1 and rd_data_o=cnt[rd_addr_i] as held before edge k.
  - The value is pre-increment if the scanner updates that counter on edge k; it is visible after edge k.
  - Out-of-range address (>= g_trig_width) returns 0 with rd_valid_o=1.
  - rd_data_o holds its value when rd_valid_o=0.
- busy_o is registered: the OR of the pending bits after the current edge.
- Back-to-back reads are allowed every cycle.

Optional Feature:
- Macro PSTATS_CLR_ON_READ_EN.
- When defined, a read of an in-range address clears cnt[addr] on the same edge that captures rd_data_o.
- If the scanner increments that counter on the same edge, the counter becomes 1, so no event is lost.
- When not defined, reads are non-destructive.

Test Plan:
- Reset with trig_i[3] held high, then release reset -> cnt[3]=0 after 20 cycles; a 0->1 on line 3 after a low cycle -> cnt[3]=1 within 10 cycles.
- Single-cycle pulses on all 10 lines simultaneously, every 20 cycles, 100 times -> every cnt[n]=100, lost_cnt_o=0.
- Line 5 pulsed 1 cycle high / 1 cycle low repeatedly (event spacing 2 cycles < g_trig_width=10) for 50 events -> cnt[5]+lost_cnt_o=50, lost_cnt_o>0.
- Preload by forcing cnt[2]=0xFFFFFFFF, then one event on line 2 -> read returns 0x00000000, rd_valid_o exactly 1 cycle after rd_req_i.
- Read line 7 on the same edge the scanner increments it (cnt=4) -> rd_data_o=4, next read=5; with PSTATS_CLR_ON_READ_EN -> rd_data_o=4, next read=1.
- clr_all_i asserted with events pending on lines 0..9 -> all reads return 0, busy_o=0 next cycle, lost_cnt_o unchanged; read of address 12 -> rd_data_o=0, rd_valid_o=1.
